// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multi-cycle RV32I sequencer: opcodes, FSM states, mux selects.
// Pure definitions, no logic; zero latency and no flow control.
package multicycle_control_unit_pkg;

   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_IARITH = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_ECALL  = 7'b1110011;

   localparam int STATE_W = 3;

   localparam logic [STATE_W-1:0] ST_IF   = 3'd0;
   localparam logic [STATE_W-1:0] ST_ID   = 3'd1;
   localparam logic [STATE_W-1:0] ST_EX   = 3'd2;
   localparam logic [STATE_W-1:0] ST_MEM  = 3'd3;
   localparam logic [STATE_W-1:0] ST_WB   = 3'd4;
   localparam logic [STATE_W-1:0] ST_BR   = 3'd5;
   localparam logic [STATE_W-1:0] ST_HALT = 3'd6;

   localparam logic [1:0] ALU_OP_ADD   = 2'b00;
   localparam logic [1:0] ALU_OP_BR    = 2'b01;
   localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

   localparam logic [1:0] WB_SEL_ALU = 2'd0;
   localparam logic [1:0] WB_SEL_MDR = 2'd1;
   localparam logic [1:0] WB_SEL_PC4 = 2'd2;

   localparam logic [1:0] SRC_B_REG = 2'd0;
   localparam logic [1:0] SRC_B_4   = 2'd1;
   localparam logic [1:0] SRC_B_IMM = 2'd2;

   typedef struct packed {
      logic is_rtype;
      logic is_iarith;
      logic is_load;
      logic is_store;
      logic is_branch;
      logic is_jal;
      logic is_jalr;
      logic is_ecall;
   } op_class_t;

   typedef struct packed {
      logic       pc_write;
      logic       pc_source;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_write;
      logic [1:0] wb_sel;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       is_halted;
   } ctrl_t;

   function automatic logic is_mem_class(input op_class_t c);
      return c.is_load | c.is_store;
   endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control-unit <-> datapath/memory bundle; master is the sequencer, slave the datapath side.
// Wires only; zero latency, memory flow control is the mem_ready level.
interface multicycle_control_unit_if;

   logic [6:0] opcode;
   logic       alu_bcond;
   logic       mem_ready;
   logic       halt_cond;

   logic       pc_write;
   logic       pc_source;
   logic       iord;
   logic       mem_read;
   logic       mem_write;
   logic       ir_write;
   logic       reg_write;
   logic [1:0] wb_sel;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] alu_op;
   logic       is_halted;

   modport master (
      input  opcode, alu_bcond, mem_ready, halt_cond,
      output pc_write, pc_source, iord, mem_read, mem_write, ir_write,
             reg_write, wb_sel, alu_src_a, alu_src_b, alu_op, is_halted
   );

   modport slave (
      output opcode, alu_bcond, mem_ready, halt_cond,
      input  pc_write, pc_source, iord, mem_read, mem_write, ir_write,
             reg_write, wb_sel, alu_src_a, alu_src_b, alu_op, is_halted
   );

endinterface

// File: rtl/multicycle_control_unit_opcode_class.sv
// Opcode to one-hot instruction-class flags; all-zero for opcodes the sequencer treats as NOP.
// Combinational, zero latency, no flow control.
module multicycle_control_unit_opcode_class
   import multicycle_control_unit_pkg::*;
(
   input  logic [6:0] opcode_i,
   output op_class_t  class_o
);

   always_comb begin
      class_o = '0;
      case (opcode_i)
         OP_RTYPE:  class_o.is_rtype  = 1'b1;
         OP_IARITH: class_o.is_iarith = 1'b1;
         OP_LOAD:   class_o.is_load   = 1'b1;
         OP_STORE:  class_o.is_store  = 1'b1;
         OP_BRANCH: class_o.is_branch = 1'b1;
         OP_JAL:    class_o.is_jal    = 1'b1;
         OP_JALR:   class_o.is_jalr   = 1'b1;
         OP_ECALL:  class_o.is_ecall  = 1'b1;
         default:   class_o = '0;
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore sequencer for the multi-cycle RV32I core: IF/ID/EX/MEM/WB/BR plus a sticky HALT state.
// Outputs decode combinationally from state; IF and MEM stall while mem_ready is low.
module multicycle_control_unit
   import multicycle_control_unit_pkg::*;
#(
   parameter int STATE_WIDTH = 3
)(
   input  logic                        clk,
   input  logic                        reset,
   multicycle_control_unit_if.master   bus
);

   localparam logic [STATE_WIDTH-1:0] S_IF   = STATE_WIDTH'(ST_IF);
   localparam logic [STATE_WIDTH-1:0] S_ID   = STATE_WIDTH'(ST_ID);
   localparam logic [STATE_WIDTH-1:0] S_EX   = STATE_WIDTH'(ST_EX);
   localparam logic [STATE_WIDTH-1:0] S_MEM  = STATE_WIDTH'(ST_MEM);
   localparam logic [STATE_WIDTH-1:0] S_WB   = STATE_WIDTH'(ST_WB);
   localparam logic [STATE_WIDTH-1:0] S_BR   = STATE_WIDTH'(ST_BR);
   localparam logic [STATE_WIDTH-1:0] S_HALT = STATE_WIDTH'(ST_HALT);

   logic [STATE_WIDTH-1:0] state_q;
   logic [STATE_WIDTH-1:0] state_d;
   op_class_t              cls;
   ctrl_t                  ctrl;

   multicycle_control_unit_opcode_class u_opcode_class (
      .opcode_i (bus.opcode),
      .class_o  (cls)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IF;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ctrl    = '0;
      case (state_q)
         S_IF: begin
            ctrl.mem_read = 1'b1;
            if (bus.mem_ready) begin
               ctrl.ir_write = 1'b1;
               state_d       = S_ID;
            end
         end
         S_ID: begin
            if (cls.is_ecall) begin
               if (bus.halt_cond) begin
                  state_d = S_HALT;
               end else begin
                  ctrl.pc_write  = 1'b1;
                  ctrl.pc_source = 1'b1;
                  state_d        = S_IF;
               end
            end else begin
               state_d = S_EX;
            end
         end
         S_EX: begin
            if (cls.is_rtype) begin
               ctrl.alu_src_a = 1'b1;
               ctrl.alu_src_b = SRC_B_REG;
               ctrl.alu_op    = ALU_OP_FUNCT;
               state_d        = S_WB;
            end else if (cls.is_iarith) begin
               ctrl.alu_src_a = 1'b1;
               ctrl.alu_src_b = SRC_B_IMM;
               ctrl.alu_op    = ALU_OP_FUNCT;
               state_d        = S_WB;
            end else if (is_mem_class(cls)) begin
               ctrl.alu_src_a = 1'b1;
               ctrl.alu_src_b = SRC_B_IMM;
               ctrl.alu_op    = ALU_OP_ADD;
               state_d        = S_MEM;
            end else if (cls.is_branch) begin
               ctrl.alu_src_a = 1'b1;
               ctrl.alu_src_b = SRC_B_REG;
               ctrl.alu_op    = ALU_OP_BR;
               if (bus.alu_bcond) begin
                  state_d = S_BR;
               end else begin
                  ctrl.pc_write  = 1'b1;
                  ctrl.pc_source = 1'b1;
                  state_d        = S_IF;
               end
            end else if (cls.is_jal || cls.is_jalr) begin
               // Link and jump share one cycle: rd <= PC+4 while PC <= ALU target.
               ctrl.alu_src_a = cls.is_jalr;
               ctrl.alu_src_b = SRC_B_IMM;
               ctrl.alu_op    = ALU_OP_ADD;
               ctrl.pc_write  = 1'b1;
               ctrl.pc_source = 1'b0;
               ctrl.reg_write = 1'b1;
               ctrl.wb_sel    = WB_SEL_PC4;
               state_d        = S_IF;
            end else begin
               ctrl.pc_write  = 1'b1;
               ctrl.pc_source = 1'b1;
               state_d        = S_IF;
            end
         end
         S_MEM: begin
            ctrl.iord      = 1'b1;
            ctrl.mem_read  = cls.is_load;
            ctrl.mem_write = cls.is_store;
            if (bus.mem_ready) begin
               if (cls.is_load) begin
                  state_d = S_WB;
               end else begin
                  ctrl.pc_write  = cls.is_store;
                  ctrl.pc_source = cls.is_store;
                  state_d        = S_IF;
               end
            end
         end
         S_WB: begin
            ctrl.reg_write = 1'b1;
            ctrl.wb_sel    = cls.is_load ? WB_SEL_MDR : WB_SEL_ALU;
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = 1'b1;
            state_d        = S_IF;
         end
         S_BR: begin
            ctrl.alu_src_a = 1'b0;
            ctrl.alu_src_b = SRC_B_IMM;
            ctrl.alu_op    = ALU_OP_ADD;
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = 1'b0;
            state_d        = S_IF;
         end
         S_HALT: begin
            ctrl.is_halted = 1'b1;
         end
         default: begin
            state_d = S_IF;
         end
      endcase
      // Reset is asynchronous, so requests must drop without waiting for an edge.
      if (!reset) begin
         ctrl = '0;
      end
   end

   assign bus.pc_write  = ctrl.pc_write;
   assign bus.pc_source = ctrl.pc_source;
   assign bus.iord      = ctrl.iord;
   assign bus.mem_read  = ctrl.mem_read;
   assign bus.mem_write = ctrl.mem_write;
   assign bus.ir_write  = ctrl.ir_write;
   assign bus.reg_write = ctrl.reg_write;
   assign bus.wb_sel    = ctrl.wb_sel;
   assign bus.alu_src_a = ctrl.alu_src_a;
   assign bus.alu_src_b = ctrl.alu_src_b;
   assign bus.alu_op    = ctrl.alu_op;
   assign bus.is_halted = ctrl.is_halted;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: each instruction is expanded into its per-cycle control trace and checked at negedge.
module tb_multicycle_control_unit;

   localparam logic [6:0] R_OP  = 7'b0110011;
   localparam logic [6:0] I_OP  = 7'b0010011;
   localparam logic [6:0] LD_OP = 7'b0000011;
   localparam logic [6:0] ST_OP = 7'b0100011;
   localparam logic [6:0] BR_OP = 7'b1100011;
   localparam logic [6:0] JL_OP = 7'b1101111;
   localparam logic [6:0] JR_OP = 7'b1100111;
   localparam logic [6:0] EC_OP = 7'b1110011;

   typedef struct packed {
      logic       pc_write;
      logic       pc_source;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_write;
      logic [1:0] wb_sel;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       is_halted;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;
   exp_t  exp_q[$];
   string name_q[$];
   exp_t  mon_e;
   string mon_n;

   always #5 clk = ~clk;

   multicycle_control_unit_if bus();

   multicycle_control_unit #(.STATE_WIDTH(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   function automatic exp_t actual();
      exp_t a;
      a.pc_write  = bus.pc_write;
      a.pc_source = bus.pc_source;
      a.iord      = bus.iord;
      a.mem_read  = bus.mem_read;
      a.mem_write = bus.mem_write;
      a.ir_write  = bus.ir_write;
      a.reg_write = bus.reg_write;
      a.wb_sel    = bus.wb_sel;
      a.alu_src_a = bus.alu_src_a;
      a.alu_src_b = bus.alu_src_b;
      a.alu_op    = bus.alu_op;
      a.is_halted = bus.is_halted;
      return a;
   endfunction

   task automatic check_now(input string nm, input exp_t e);
      exp_t a;
      a = actual();
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, a, e);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         mon_n = name_q.pop_front();
         check_now(mon_n, mon_e);
      end
   end

   task automatic step(input string nm, input exp_t e, input logic [6:0] op,
                       input logic bc, input logic hc, input logic rdy);
      @(posedge clk);
      #1;
      bus.opcode    = op;
      bus.alu_bcond = bc;
      bus.halt_cond = hc;
      bus.mem_ready = rdy;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   // Reference trace: the control word each cycle of one instruction must show.
   task automatic run_instr(input logic [6:0] op, input logic bc, input logic hc,
                            input int if_wait, input int mem_wait);
      exp_t e;
      for (int i = 0; i < if_wait; i++) begin
         e = '0; e.mem_read = 1'b1;
         step("IF_wait", e, op, bc, hc, 1'b0);
      end
      e = '0; e.mem_read = 1'b1; e.ir_write = 1'b1;
      step("IF", e, op, bc, hc, 1'b1);
      e = '0;
      if (op == EC_OP && !hc) begin
         e.pc_write = 1'b1; e.pc_source = 1'b1;
      end
      step("ID", e, op, bc, hc, rbit());
      if (op == EC_OP) return;
      e = '0;
      case (op)
         R_OP, I_OP: begin
            e.alu_src_a = 1'b1; e.alu_op = 2'b10;
            e.alu_src_b = (op == I_OP) ? 2'd2 : 2'd0;
            step("EX_arith", e, op, bc, hc, rbit());
            e = '0; e.reg_write = 1'b1; e.pc_write = 1'b1; e.pc_source = 1'b1;
            step("WB_arith", e, op, bc, hc, rbit());
         end
         LD_OP, ST_OP: begin
            e.alu_src_a = 1'b1; e.alu_src_b = 2'd2;
            step("EX_mem", e, op, bc, hc, 1'b0);
            e = '0; e.iord = 1'b1;
            e.mem_read = (op == LD_OP); e.mem_write = (op == ST_OP);
            for (int i = 0; i < mem_wait; i++) step("MEM_wait", e, op, bc, hc, 1'b0);
            if (op == ST_OP) begin
               e.pc_write = 1'b1; e.pc_source = 1'b1;
            end
            step("MEM", e, op, bc, hc, 1'b1);
            if (op == LD_OP) begin
               e = '0; e.reg_write = 1'b1; e.wb_sel = 2'd1;
               e.pc_write = 1'b1; e.pc_source = 1'b1;
               step("WB_load", e, op, bc, hc, rbit());
            end
         end
         BR_OP: begin
            e.alu_src_a = 1'b1; e.alu_op = 2'b01;
            e.pc_write = !bc; e.pc_source = !bc;
            step("EX_branch", e, op, bc, hc, rbit());
            if (bc) begin
               e = '0; e.alu_src_b = 2'd2; e.pc_write = 1'b1;
               step("BR_taken", e, op, bc, hc, rbit());
            end
         end
         JL_OP, JR_OP: begin
            e.alu_src_a = (op == JR_OP); e.alu_src_b = 2'd2;
            e.pc_write = 1'b1; e.reg_write = 1'b1; e.wb_sel = 2'd2;
            step("EX_jump", e, op, bc, hc, rbit());
         end
         default: begin
            e.pc_write = 1'b1; e.pc_source = 1'b1;
            step("EX_nop", e, op, bc, hc, rbit());
         end
      endcase
   endtask

   logic [6:0] ops [10];
   exp_t       e0;

   initial begin
      ops = '{R_OP, I_OP, LD_OP, ST_OP, BR_OP, JL_OP, JR_OP, EC_OP, 7'b0110111, 7'b1111111};
      reset         = 1'b0;
      bus.opcode    = R_OP;
      bus.alu_bcond = 1'b0;
      bus.mem_ready = 1'b1;
      bus.halt_cond = 1'b0;
      #2;
      check_now("reset_state", '0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      bus.mem_ready = 1'b0;
      reset = 1'b1;

      run_instr(R_OP,  1'b0, 1'b0, 0, 0);
      run_instr(LD_OP, 1'b0, 1'b0, 0, 3);
      run_instr(BR_OP, 1'b0, 1'b0, 0, 0);
      run_instr(BR_OP, 1'b1, 1'b0, 0, 0);
      run_instr(JL_OP, 1'b0, 1'b0, 0, 0);
      run_instr(JR_OP, 1'b1, 1'b0, 1, 0);
      run_instr(EC_OP, 1'b0, 1'b0, 0, 0);
      run_instr(ST_OP, 1'b0, 1'b1, 2, 0);

      for (int n = 0; n < 60; n++) begin
         logic [6:0] op;
         op = ops[$urandom_range(0, 9)];
         run_instr(op, rbit(), (op == EC_OP) ? 1'b0 : rbit(),
                   $urandom_range(0, 2), $urandom_range(0, 3));
      end

      // STORE stalled in MEM, then reset between edges.
      e0 = '0; e0.mem_read = 1'b1; e0.ir_write = 1'b1;
      step("IF", e0, ST_OP, 1'b0, 1'b0, 1'b1);
      step("ID", '0, ST_OP, 1'b0, 1'b0, 1'b0);
      e0 = '0; e0.alu_src_a = 1'b1; e0.alu_src_b = 2'd2;
      step("EX_mem", e0, ST_OP, 1'b0, 1'b0, 1'b0);
      e0 = '0; e0.iord = 1'b1; e0.mem_write = 1'b1;
      step("MEM_wait", e0, ST_OP, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      #1;
      check_now("mem_write_before_reset", e0);
      reset = 1'b0;
      #1;
      check_now("reset_drops_request", '0);
      @(posedge clk);
      #1;
      check_now("reset_held", '0);
      bus.mem_ready = 1'b0;
      reset = 1'b1;
      #1;
      e0 = '0; e0.mem_read = 1'b1;
      check_now("post_reset_IF", e0);
      run_instr(I_OP, 1'b0, 1'b0, 0, 0);

      // ECALL with x17 == 10 parks the sequencer in HALT.
      run_instr(EC_OP, 1'b0, 1'b1, 0, 0);
      e0 = '0; e0.is_halted = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step("HALT", e0, ops[$urandom_range(0, 9)], rbit(), rbit(), rbit());
      end
      @(negedge clk);
      #1;
      reset = 1'b0;
      #1;
      check_now("reset_clears_halt", '0);
      @(posedge clk);
      #1;
      bus.mem_ready = 1'b0;
      reset = 1'b1;
      #1;
      e0 = '0; e0.mem_read = 1'b1;
      check_now("IF_after_halt_reset", e0);

      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog time=%0t required=finish", $time);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Moore-style sequencer for the multi-cycle RV32I CPU. It steps each instruction through fetch, decode, execute, memory and write-back. It drives the register-file write enable, the ALU/PC/memory mux selects and the shared instruction/data memory handshake. It also owns the sticky halt state raised by ECALL when the register file reports x17 == 10.

Parameters:
STATE_WIDTH, 3, width of the state register; must encode the 7 states below.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (0 = in reset)
opcode  in  7  instruction-register bits [6:0]
alu_bcond  in  1  branch comparison result from the ALU, valid in EX
mem_ready  in  1  shared memory completed the current read/write this cycle
halt_cond  in  1  register-file compare: x17 == 10
pc_write  out  1  load PC at the next edge
pc_source  out  1  0 = ALU result, 1 = PC+4 adder
iord  out  1  memory address: 0 = PC, 1 = ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  latch instruction register
reg_write  out  1  register-file write enable (RegWrite)
wb_sel  out  2  rd data: 0 = ALUOut, 1 = MDR, 2 = PC+4
alu_src_a  out  1  0 = PC, 1 = A register
alu_src_b  out  2  0 = B register, 1 = constant 4, 2 = immediate
alu_op  out  2  00 = add, 01 = branch compare, 10 = funct-decoded
is_halted  out  1  sticky halt flag

Behaviour:
- State register is asynchronous-reset to IF. Other flops update on the rising clk edge.
- Outputs decode combinationally from the state, opcode, mem_ready, alu_bcond and halt_cond. Every output defaults to 0 in every state unless listed below.
- During reset all outputs are 0 and is_halted is 0.
- IF:
  - Drives mem_read=1 and iord=0.
  - If mem_ready=0, holds in IF.
  - If mem_ready=1, asserts ir_write=1 in the same cycle and moves to ID.
- ID (decode only, 1 cycle):
  - ECALL (1110011) with halt_cond=1: moves to HALT.
  - ECALL with halt_cond=0: asserts pc_write=1, pc_source=1 and moves to IF.
  - Any other opcode: moves to EX.
- EX:
  - R-type (0110011): alu_src_a=1, alu_src_b=0, alu_op=10; moves to WB.
  - I-arith (0010011): alu_src_a=1, alu_src_b=2, alu_op=10; moves to WB.
  - LOAD (0000011) / STORE (0100011): alu_src_a=1, alu_src_b=2, alu_op=00; moves to MEM.
  - BRANCH (1100011): alu_src_a=1, alu_src_b=0, alu_op=01.
    - alu_bcond=1: moves to BR.
    - alu_bcond=0: asserts pc_write=1, pc_source=1 and moves to IF.
  - JAL (1101111): alu_src_a=0, alu_src_b=2, alu_op=00, pc_write=1, pc_source=0, reg_write=1, wb_sel=2; moves to IF.
  - JALR (1100111): same as JAL but alu_src_a=1. The datapath clears target bit 0.
  - Unknown opcode: executes as a NOP (pc_write=1, pc_source=1) and moves to IF.
- BR: alu_src_a=0, alu_src_b=2, alu_op=00, pc_write=1, pc_source=0; moves to IF.
- MEM:
  - Drives iord=1, with mem_read=1 for LOAD or mem_write=1 for STORE.
  - If mem_ready=0, holds in MEM with the request level held.
  - LOAD with mem_ready=1: moves to WB.
  - STORE with mem_ready=1: asserts pc_write=1, pc_source=1 and moves to IF.
- WB:
  - reg_write=1; wb_sel=1 for LOAD, otherwise 0.
  - Also asserts pc_write=1, pc_source=1; moves to IF.
- HALT:
  - Absorbing state; only reset leaves it.
  - is_halted=1 and all other outputs 0.
- Memory requests are level signals. mem_read and mem_write are never both 1.
- Asserting reset while the block waits in IF or MEM drops the request in the same cycle (asynchronous). After reset release, fetch restarts in IF.
- Cycle counts with zero-wait memory (mem_ready=1 on the request cycle):
  - R-type / I-arith: 4.
  - LOAD: 5.
  - STORE: 4.
  - Branch not taken: 3; taken: 4.
  - JAL / JALR: 3.
  - ECALL without halt: 2.

Decomposition:
- Shared header control_defs:
  - opcode constants
  - state encodings: IF=0, ID=1, EX=2, MEM=3, WB=4, BR=5, HALT=6
  - alu_op, wb_sel and alu_src_b encodings
- Sub-module opcode_class: combinational, turns opcode into one-hot class flags (is_rtype, is_iarith, is_load, is_store, is_branch, is_jal, is_jalr, is_ecall).

Test Plan:
- ADD (opcode 0110011), mem_ready always 1 -> states IF, ID, EX, WB; reg_write=1 with wb_sel=0 only in WB; pc_write=1, pc_source=1 in WB; 4 cycles total.
- LW with mem_ready low for 3 cycles in MEM -> mem_read=1, iord=1 held for 4 cycles; WB with wb_sel=1; 8 cycles total.
- BEQ, first alu_bcond=0 then alu_bcond=1:
  - not taken: pc_write=1, pc_source=1 in EX; 3 cycles.
  - taken: BR asserts alu_src_b=2, pc_source=0; 4 cycles.
- JAL -> EX asserts reg_write=1, wb_sel=2 and pc_write=1, pc_source=0 in the same cycle; next state IF.
- ECALL:
  - halt_cond=1 -> is_halted=1 from the cycle after ID and stays 1 for 20 cycles with all other outputs 0.
  - halt_cond=0 -> PC+4 and back to IF.
- Reset driven to 0 mid-MEM of a STORE -> mem_write falls to 0 without a clock edge; after release, first cycle is IF with mem_read=1, iord=0; is_halted=0.
